// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter:
// lock FSM states, requester indices and parameter defaults.
package dmem_arbiter_pkg;

  // Requester indices: port 0 is the processor, port 1 the DMA/loader.
  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

  // Parameter defaults shared by the top and the selector.
  localparam int LOCK_MAX_DEF = 8;
  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 32;

  // Lock FSM: either free round-robin or one port holding the grant.
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED_0 = 2'd1,
    ST_LOCKED_1 = 2'd2
  } lock_state_t;

  // One-hot grant vector for a single port index.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the RAM.
// slave: the arbiter side; master: requesters plus the RAM model.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              req0, we0, lock0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0, rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1, we1, lock1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1, rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic              ram_wEn;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dataIn;
  logic [DATA_W-1:0] ram_dataOut;

  modport slave (
    input  req0, we0, lock0, addr0, wdata0,
    input  req1, we1, lock1, addr1, wdata1,
    input  ram_dataOut,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output ram_wEn, ram_addr, ram_dataIn
  );

  modport master (
    output req0, we0, lock0, addr0, wdata0,
    output req1, we1, lock1, addr1, wdata1,
    output ram_dataOut,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  ram_wEn, ram_addr, ram_dataIn
  );
endinterface

// File: rtl/dmem_arbiter_rr_lock_sel.sv
// Grant selector: round-robin pointer, lock FSM and lock-run counter.
// The grant is combinational; the lock state advances on the clock edge.
module rr_lock_sel
  import dmem_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  output logic [1:0] gnt_o
);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic             ptr_q;     // port preferred on contention
  lock_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;     // consecutive locked grants, 1 on entry

  logic             lock_active;
  logic             lock_port;
  logic [1:0]       gnt_c;
  logic             win_port;
  logic [CNT_W-1:0] cnt_inc;

  assign lock_active = (state_q != ST_UNLOCKED);
  assign lock_port   = (state_q == ST_LOCKED_1);
  assign win_port    = gnt_c[1];
  assign cnt_inc     = cnt_q + 1'b1;
  assign gnt_o       = gnt_c;

  // Pick the winner: lock holder first, then pointer on contention, else lone requester.
  always_comb begin
    gnt_c = 2'b00;
    if (reset) begin
      gnt_c = 2'b00;
    end else if (lock_active && req_i[lock_port]) begin
      gnt_c = port_onehot(lock_port);
    end else if (req_i == 2'b11) begin
      gnt_c = port_onehot(ptr_q);
    end else begin
      gnt_c = req_i;
    end
  end

  // Pointer, lock FSM and lock counter; the counter hitting LOCK_MAX exits the lock
  // immediately so the following arbitration is plain round-robin.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q   <= 1'(PORT_CPU);
      state_q <= ST_UNLOCKED;
      cnt_q   <= '0;
    end else begin
      if (|gnt_c) begin
        ptr_q <= win_port ? 1'(PORT_CPU) : 1'(PORT_DMA);
      end
      case (state_q)
        ST_UNLOCKED: begin
          if ((|gnt_c) && lock_i[win_port] && (LOCK_MAX > 1)) begin
            state_q <= win_port ? ST_LOCKED_1 : ST_LOCKED_0;
            cnt_q   <= CNT_W'(1);
          end
        end
        ST_LOCKED_0, ST_LOCKED_1: begin
          if (!req_i[lock_port]) begin
            // Holder stepped away: the lock is abandoned.
            state_q <= ST_UNLOCKED;
            cnt_q   <= '0;
          end else if (!lock_i[lock_port] || (cnt_inc == CNT_W'(LOCK_MAX))) begin
            state_q <= ST_UNLOCKED;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= ST_UNLOCKED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port single-RAM arbiter: grant selection is delegated to rr_lock_sel;
// this level muxes the winner onto the RAM and routes read data back.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rd_issue;

  logic [ADDR_W-1:0] addr_q;      // last address driven to the RAM
  logic [DATA_W-1:0] din_q;       // last write data driven to the RAM
  logic              rd_valid_q;  // a read was captured by the RAM last edge
  logic              rd_owner_q;  // which port that read belongs to

  rr_lock_sel #(
    .LOCK_MAX (LOCK_MAX)
  ) u_sel (
    .clock  (clock),
    .reset  (reset),
    .req_i  ({bus.req1, bus.req0}),
    .lock_i ({bus.lock1, bus.lock0}),
    .gnt_o  (gnt)
  );

  assign any_gnt   = |gnt;
  assign sel_we    = gnt[PORT_DMA] ? bus.we1    : bus.we0;
  assign sel_addr  = gnt[PORT_DMA] ? bus.addr1  : bus.addr0;
  assign sel_wdata = gnt[PORT_DMA] ? bus.wdata1 : bus.wdata0;
  assign rd_issue  = any_gnt && !sel_we;

  assign bus.gnt0       = gnt[PORT_CPU];
  assign bus.gnt1       = gnt[PORT_DMA];
  assign bus.ram_wEn    = any_gnt && sel_we;
  assign bus.ram_addr   = any_gnt ? sel_addr  : addr_q;
  assign bus.ram_dataIn = any_gnt ? sel_wdata : din_q;

  // Read return: gated by reset so an in-flight read never surfaces during reset.
  assign bus.rvalid0 = rd_valid_q && (rd_owner_q == 1'(PORT_CPU)) && !reset;
  assign bus.rvalid1 = rd_valid_q && (rd_owner_q == 1'(PORT_DMA)) && !reset;
  assign bus.rdata0  = bus.rvalid0 ? bus.ram_dataOut : '0;
  assign bus.rdata1  = bus.rvalid1 ? bus.ram_dataOut : '0;

  // Hold the RAM-side address/data between grants and tag the in-flight read.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      din_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'(PORT_CPU);
    end else begin
      if (any_gnt) begin
        addr_q <= sel_addr;
        din_q  <= sel_wdata;
      end
      rd_valid_q <= rd_issue;
      if (rd_issue) begin
        rd_owner_q <= gnt[PORT_DMA];
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a per-cycle reference model of the
// arbitration and read-return rules plus literal scenario expectations.
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LM = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Simple RAM: write and registered read, both on the rising edge.
  logic [DW-1:0] ram_mem [0:4095];
  always @(posedge clock) begin
    if (bus.ram_wEn) ram_mem[bus.ram_addr] <= bus.ram_dataIn;
    bus.ram_dataOut <= ram_mem[bus.ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] shadow [0:4095];
  int            m_last;   // port granted most recently (1 => port 0 preferred)
  int            m_owner;  // lock holder, -1 when free
  int            m_run;    // consecutive locked grants
  bit            m_pv;
  int            m_pp;
  logic [DW-1:0] m_pd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  bit            r [2];
  bit            w [2];
  bit            l [2];
  logic [AW-1:0] a [2];
  logic [DW-1:0] d [2];
  int            win;

  initial begin
    for (int i = 0; i < 4096; i++) shadow[i] = '0;
    m_last = 1; m_owner = -1; m_run = 0; m_pv = 0; m_pp = 0; m_pd = '0;
    m_addr = '0; m_din = '0;
  end

  always @(negedge clock) begin
    r[0] = bus.req0; w[0] = bus.we0; l[0] = bus.lock0; a[0] = bus.addr0; d[0] = bus.wdata0;
    r[1] = bus.req1; w[1] = bus.we1; l[1] = bus.lock1; a[1] = bus.addr1; d[1] = bus.wdata1;

    chk("model rvalid0", 32'(bus.rvalid0), 32'(!reset && m_pv && m_pp == 0));
    chk("model rdata0", bus.rdata0, (!reset && m_pv && m_pp == 0) ? m_pd : '0);
    chk("model rvalid1", 32'(bus.rvalid1), 32'(!reset && m_pv && m_pp == 1));
    chk("model rdata1", bus.rdata1, (!reset && m_pv && m_pp == 1) ? m_pd : '0);

    if (reset) begin
      chk("model gnt0", 32'(bus.gnt0), 0);
      chk("model gnt1", 32'(bus.gnt1), 0);
      chk("model wen", 32'(bus.ram_wEn), 0);
      m_last = 1; m_owner = -1; m_run = 0; m_pv = 0; m_addr = '0; m_din = '0;
    end else begin
      win = -1;
      if (m_owner >= 0 && r[m_owner]) win = m_owner;
      else if (r[0] && r[1])          win = 1 - m_last;
      else if (r[0])                  win = 0;
      else if (r[1])                  win = 1;

      chk("model gnt0", 32'(bus.gnt0), 32'(win == 0));
      chk("model gnt1", 32'(bus.gnt1), 32'(win == 1));
      chk("model wen", 32'(bus.ram_wEn), 32'(win >= 0 && w[win]));
      chk("model addr", 32'(bus.ram_addr), 32'((win >= 0) ? a[win] : m_addr));
      chk("model din", bus.ram_dataIn, (win >= 0) ? d[win] : m_din);

      m_pv = 0;
      if (win >= 0) begin
        $display("txn t=%0t port=%0d %s addr=%h data=%h", $time, win,
                 w[win] ? "WR" : "RD", a[win], w[win] ? d[win] : shadow[a[win]]);
        m_addr = a[win];
        m_din  = d[win];
        if (w[win]) shadow[a[win]] = d[win];
        else begin m_pv = 1; m_pp = win; m_pd = shadow[a[win]]; end
        m_last = win;
      end
      if (m_owner >= 0) begin
        if (!r[m_owner] || !l[m_owner] || (m_run + 1 >= LM)) begin
          m_owner = -1; m_run = 0;
        end else begin
          m_run++;
        end
      end else if (win >= 0 && l[win] && LM > 1) begin
        m_owner = win; m_run = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input int p, input bit rq, input bit we, input bit lk,
                       input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    if (p == 0) begin
      bus.req0 = rq; bus.we0 = we; bus.lock0 = lk; bus.addr0 = ad; bus.wdata0 = wd;
    end else begin
      bus.req1 = rq; bus.we1 = we; bus.lock1 = lk; bus.addr1 = ad; bus.wdata1 = wd;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1, 1, 0, 12'h055, 32'hAAAA_5555);
    drive(1, 1, 0, 0, 12'h066, 32'h0);
    tick();
    settle();
    chk("rst gnt0", 32'(bus.gnt0), 0);
    chk("rst gnt1", 32'(bus.gnt1), 0);
    chk("rst wen", 32'(bus.ram_wEn), 0);
    chk("rst rvalid0", 32'(bus.rvalid0), 0);
    tick();
    settle();
    chk("rst addr", 32'(bus.ram_addr), 0);
    chk("rst din", bus.ram_dataIn, 0);
    reset = 1'b0;
    idle();
    tick();

    // Preload through the loader port.
    drive(1, 1, 1, 0, 12'h010, 32'hDEAD_BEEF); tick();
    drive(1, 1, 1, 0, 12'h001, 32'h0000_0011); tick();
    drive(1, 1, 1, 0, 12'h002, 32'h0000_0022); tick();
    do_reset();

    // Lone read by port 0.
    drive(0, 1, 0, 0, 12'h010, '0);
    settle();
    chk("s34 gnt0", 32'(bus.gnt0), 1);
    chk("s34 gnt1", 32'(bus.gnt1), 0);
    tick();
    idle();
    settle();
    chk("s34 rvalid0", 32'(bus.rvalid0), 1);
    chk("s34 rdata0", bus.rdata0, 32'hDEAD_BEEF);
    chk("s34 rvalid1", 32'(bus.rvalid1), 0);
    tick();
    settle();
    chk("s34 rvalid0 once", 32'(bus.rvalid0), 0);
    chk("s34 rdata0 zero", bus.rdata0, 0);
    tick();

    // Contention alternates; reads return to their own port.
    do_reset();
    drive(0, 1, 0, 0, 12'h001, '0);
    drive(1, 1, 0, 0, 12'h002, '0);
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("s35 gnt0", 32'(bus.gnt0), 32'(i % 2 == 0));
      chk("s35 gnt1", 32'(bus.gnt1), 32'(i % 2 == 1));
      if (i > 0) begin
        chk("s38 rdata0", bus.rdata0, (i % 2 == 1) ? 32'h11 : 32'h0);
        chk("s38 rdata1", bus.rdata1, (i % 2 == 0) ? 32'h22 : 32'h0);
      end
      tick();
    end
    idle();
    settle();
    chk("s38 last rvalid1", 32'(bus.rvalid1), 1);
    chk("s38 last rdata1", bus.rdata1, 32'h22);
    chk("s38 last rvalid0", 32'(bus.rvalid0), 0);
    tick();

    // Write by port 0 then read of the same word by port 1.
    drive(0, 1, 1, 0, 12'h020, 32'h0000_0005);
    settle();
    chk("s37 gnt0", 32'(bus.gnt0), 1);
    chk("s37 wen", 32'(bus.ram_wEn), 1);
    chk("s37 addr", 32'(bus.ram_addr), 32'h020);
    chk("s37 din", bus.ram_dataIn, 32'h5);
    tick();
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 1, 0, 0, 12'h020, '0);
    settle();
    chk("s37 gnt1", 32'(bus.gnt1), 1);
    chk("s37 no wr rvalid", 32'(bus.rvalid0), 0);
    tick();
    idle();
    settle();
    chk("s37 rvalid1", 32'(bus.rvalid1), 1);
    chk("s37 rdata1", bus.rdata1, 32'h5);
    chk("s37 addr hold", 32'(bus.ram_addr), 32'h020);
    chk("s37 wen idle", 32'(bus.ram_wEn), 0);
    tick();

    // Port 1 holds a lock against a waiting port 0 until LOCK_MAX.
    do_reset();
    drive(1, 1, 0, 1, 12'h002, '0);
    for (int i = 0; i < 12; i++) begin
      if (i == 1)  drive(0, 1, 0, 0, 12'h001, '0);
      if (i == 10) drive(1, 1, 0, 0, 12'h002, '0);
      settle();
      chk("s36 gnt1", 32'(bus.gnt1), 32'(i < 8 || i == 9 || i == 10));
      chk("s36 gnt0", 32'(bus.gnt0), 32'(i == 8 || i == 11));
      tick();
    end
    idle();
    tick();

    // Reset right after a locked read by port 0.
    do_reset();
    drive(0, 1, 0, 1, 12'h001, '0);
    settle();
    chk("s39 gnt0", 32'(bus.gnt0), 1);
    tick();
    reset = 1'b1;
    settle();
    chk("s39 rvalid0 dropped", 32'(bus.rvalid0), 0);
    chk("s39 gnt0 in reset", 32'(bus.gnt0), 0);
    tick();
    settle();
    chk("s39 rvalid0 later", 32'(bus.rvalid0), 0);
    tick();
    reset = 1'b0;
    drive(0, 1, 0, 0, 12'h001, '0);
    drive(1, 1, 0, 0, 12'h002, '0);
    settle();
    chk("s39 post gnt0", 32'(bus.gnt0), 1);
    chk("s39 no stale rvalid", 32'(bus.rvalid0), 0);
    tick();
    settle();
    chk("s39 post gnt1", 32'(bus.gnt1), 1);
    tick();

    // Lock holder stops requesting: the other port gets in and the lock is gone.
    idle();
    drive(0, 1, 0, 1, 12'h001, '0);
    settle();
    chk("drop gnt0", 32'(bus.gnt0), 1);
    tick();
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 1, 0, 0, 12'h002, '0);
    settle();
    chk("drop gnt1", 32'(bus.gnt1), 1);
    tick();
    drive(0, 1, 0, 0, 12'h001, '0);
    drive(1, 1, 0, 0, 12'h002, '0);
    settle();
    chk("drop rr gnt0", 32'(bus.gnt0), 1);
    tick();
    idle();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
